instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the 16-bit RISC pipeline, upstream of the execute/memory datapath. Owns the PC.
//  Drives a synchronous instruction ROM and presents the fetched word to decode, which generates reg addresses, ALU_con, offset, etc.
//  Handles stall, branch redirect from E, interrupt entry (internal_IRQ) and return-from-interrupt.
// PARAMETERS
//  PC_WIDTH      12       instruction address width
//  RESET_VECTOR  12'h000  first fetch address after reset
//  IRQ_VECTOR    12'h004  interrupt service entry address
// PORTS
//  clock            in   1         single clock, rising edge
//  reset_n          in   1         asynchronous, active-low reset
//  stall_f          in   1         hold PC and D-stage word (load-use hazard)
//  branch_taken_e   in   1         branch/jump resolved taken in E
//  branch_target_e  in   PC_WIDTH  redirect address
//  reti_e           in   1         return-from-interrupt in E
//  irq              in   1         level interrupt request (IO internal_IRQ)
//  instr_adr        out  PC_WIDTH  ROM address (combinational next_pc)
//  instr_data       in   16        ROM data; registered, valid 1 cycle after instr_adr
//  instr_d          out  16        instruction in D (= instr_data)
//  pc_d             out  PC_WIDTH  address of instr_d
//  valid_d          out  1         instr_d is real; 0 = bubble, decode issues NOP
//  irq_ack          out  1         1-cycle pulse: IRQ taken; hazard unit flushes D->E as for flush_e
//  epc              out  PC_WIDTH  saved return address
// BEHAVIOUR
//  - Reset (async, reset_n=0): pc_d=RESET_VECTOR, valid_d=0, irq_ack=0, epc=0, ie=1, state=BOOT; instr_adr=RESET_VECTOR.
//  - States: BOOT -> RUN unconditionally after 1 cycle (ROM priming; valid_d=0 during BOOT).
//    RUN -> ISR on IRQ take; ISR -> RUN on reti_e. ie=1 in RUN, 0 in ISR; irq is ignored in ISR (no nesting).
//  - next_pc priority, evaluated each cycle:
//    1) branch_taken_e -> branch_target_e.
//    2) reti_e -> epc.
//    3) IRQ take (RUN, irq=1, !branch_taken_e, !reti_e, !stall_f) -> IRQ_VECTOR.
//    4) stall_f -> pc_d (ROM re-reads same word).
//    5) otherwise pc_d+1.
//  - pc_d <= next_pc each edge. Latency: address at edge n is visible on instr_d after edge n+1.
//  - Redirect (1, 2) overrides stall_f. The wrong-path word in D is flushed externally via flush_e.
//    valid_d stays 1 after a redirect.
//  - IRQ take: epc <= pc_d (the D instruction is squashed and re-executed after reti), irq_ack=1 for exactly one cycle, state<=ISR.
//    irq blocked by a redirect or stall_f is retried on the next eligible cycle.
//  - valid_d: 0 in BOOT, else 1. A bubble shifted into D by stall stays under hazard-unit control.
//  - PC arithmetic is modulo 2^PC_WIDTH: pc_d=12'hFFF increments to 12'h000 with no flag.
//  - Simultaneous branch_taken_e and reti_e: branch wins, state unchanged.
// CONFIGURATION
//  FETCH_IRQ_EN defined: IRQ logic, ISR state and epc as above.
//  Undefined: irq ignored; irq_ack=0; epc=0; reti_e treated as no-op; FSM is BOOT->RUN only.
// STRUCTURE
//  Shared package/header fetch_defs: state encodings (BOOT=2'd0, RUN=2'd1, ISR=2'd2), default vectors, NOP encoding 16'h0000.
//  One sub-module: pc_next_mux (combinational priority select of next_pc). The FSM and registers stay in the top.
// TESTING
//  1. Reset release, ROM[n]=16'h1000+n: instr_adr 000,001,002; valid_d=0 in cycle 1, then instr_d=1000,1001 with pc_d=000,001.
//  2. stall_f=1 for 2 cycles at pc_d=005: pc_d and instr_d hold 005/1005; resume at 006.
//  3. branch_taken_e=1, target=12'h040, with stall_f=1 same cycle: next instr_d=1040, pc_d=040.
//  4. FETCH_IRQ_EN: irq=1 at pc_d=010: irq_ack pulses 1 cycle, epc=010, fetch 004.
//     irq held high in ISR causes no 2nd ack; reti_e resumes fetch at 010.
//  5. irq with branch_taken_e same cycle: branch to 020 first; IRQ taken next cycle with epc=020.
//  6. pc_d=FFF wraps to 000. reset_n low mid-ISR: immediate return to BOOT, epc=0, ie=1.
//     Without FETCH_IRQ_EN, irq=1 never changes fetch sequence.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_defs
// Shared definitions for the fetch stage of the 16-bit RISC pipeline:
// fetch FSM state encodings, default address vectors and the NOP encoding
// that decode substitutes for a bubble.
// ---------------------------------------------------------------------------
package fetch_defs;

    // Fetch FSM states. BOOT primes the synchronous ROM, RUN is normal
    // fetching, ISR is interrupt service (interrupts masked).
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ISR  = 2'd2
    } fetch_state_t;

    localparam int unsigned DEF_PC_WIDTH     = 12;
    localparam logic [11:0] DEF_RESET_VECTOR = 12'h000;
    localparam logic [11:0] DEF_IRQ_VECTOR   = 12'h004;
    localparam logic [15:0] NOP_INSTR        = 16'h0000;

endpackage

// File: rtl/instruction_fetch_pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
// Combinational priority select of the next fetch address.
// Ports:
//   i_boot          - fetch FSM in BOOT: hold the current address
//   i_branch_taken  - branch/jump resolved taken in E
//   i_branch_target - redirect address from E
//   i_reti          - return-from-interrupt accepted
//   i_epc           - saved return address
//   i_irq_take      - interrupt accepted this cycle
//   i_stall         - load-use stall, re-read the current word
//   i_pc            - address of the word currently in D
//   o_next_pc       - address presented to the ROM this cycle
// ---------------------------------------------------------------------------
module pc_next_mux
    import fetch_defs::*;
#(
    parameter int unsigned          PC_WIDTH   = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  IRQ_VECTOR = DEF_IRQ_VECTOR
) (
    input  logic                i_boot,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_reti,
    input  logic [PC_WIDTH-1:0] i_epc,
    input  logic                i_irq_take,
    input  logic                i_stall,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    // Redirects beat the stall because the stalled word is on the wrong
    // path anyway. During BOOT the reset vector is re-presented so the
    // ROM output is valid for the first real cycle. The increment wraps
    // silently at the top of the address space.
    always_comb begin
        o_next_pc = i_pc + PC_WIDTH'(1);
        if (i_boot) begin
            o_next_pc = i_pc;
        end else if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end else if (i_reti) begin
            o_next_pc = i_epc;
        end else if (i_irq_take) begin
            o_next_pc = IRQ_VECTOR;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, drives a synchronous instruction ROM and hands
// the fetched word to decode. Handles stall, branch redirect from E,
// interrupt entry and return-from-interrupt.
// Configuration macro: FETCH_IRQ_EN enables interrupt entry, the ISR state
// and epc. Without it irq and reti_e are ignored, irq_ack and epc are 0.
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   stall_f          - hold PC and D word
//   branch_taken_e   - taken branch/jump in E
//   branch_target_e  - redirect address
//   reti_e           - return-from-interrupt in E
//   irq              - level interrupt request
//   instr_adr        - ROM address (combinational next PC)
//   instr_data       - registered ROM data
//   instr_d          - instruction in D
//   pc_d             - address of instr_d
//   valid_d          - instr_d is real (0 during BOOT)
//   irq_ack          - one-cycle pulse when an interrupt is taken
//   epc              - saved return address
// ---------------------------------------------------------------------------
module instruction_fetch
    import fetch_defs::*;
#(
    parameter int unsigned          PC_WIDTH     = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [PC_WIDTH-1:0]  IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                stall_f,
    input  logic                branch_taken_e,
    input  logic [PC_WIDTH-1:0] branch_target_e,
    input  logic                reti_e,
    input  logic                irq,
    output logic [PC_WIDTH-1:0] instr_adr,
    input  logic [15:0]         instr_data,
    output logic [15:0]         instr_d,
    output logic [PC_WIDTH-1:0] pc_d,
    output logic                valid_d,
    output logic                irq_ack,
    output logic [PC_WIDTH-1:0] epc
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_epc;
    logic                w_boot;
    logic                w_ie;
    logic                w_irq_take;
    logic                w_reti_take;

    assign w_boot = (r_state == ST_BOOT);
    assign w_ie   = (r_state != ST_ISR);

`ifdef FETCH_IRQ_EN
    logic [PC_WIDTH-1:0] r_epc;

    // An interrupt is only taken on a clean cycle; if a redirect or stall
    // blocks it, the level-sensitive irq is simply seen again next cycle.
    assign w_irq_take  = w_ie && !w_boot && irq && !branch_taken_e &&
                         !reti_e && !stall_f;
    assign w_reti_take = reti_e;

    // The word in D is squashed on entry, so its own address is the
    // return point and it is re-executed after reti.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_epc <= '0;
        end else if (w_irq_take) begin
            r_epc <= r_pc;
        end
    end

    assign w_epc = r_epc;
`else
    logic w_unused_irq;

    assign w_unused_irq = irq ^ reti_e ^ w_ie;
    assign w_irq_take   = 1'b0;
    assign w_reti_take  = 1'b0;
    assign w_epc        = '0;
`endif

    // Fetch FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch FSM next state. A branch arriving with reti wins and keeps
    // the stage in ISR.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_irq_take) begin
                    w_state_next = ST_ISR;
                end
            end
            ST_ISR: begin
                if (w_reti_take && !branch_taken_e) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    pc_next_mux #(
        .PC_WIDTH   (PC_WIDTH),
        .IRQ_VECTOR (IRQ_VECTOR)
    ) u_pc_next_mux (
        .i_boot          (w_boot),
        .i_branch_taken  (branch_taken_e),
        .i_branch_target (branch_target_e),
        .i_reti          (w_reti_take),
        .i_epc           (w_epc),
        .i_irq_take      (w_irq_take),
        .i_stall         (stall_f),
        .i_pc            (r_pc),
        .o_next_pc       (w_next_pc)
    );

    // PC register: tracks the address that the ROM is reading, so after
    // each edge it names the word appearing on instr_data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign instr_adr = w_next_pc;
    assign instr_d   = instr_data;
    assign pc_d      = r_pc;
    assign valid_d   = !w_boot;
    assign irq_ack   = w_irq_take;
    assign epc       = w_epc;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. A small reference model of the
// fetch rules is compared against the DUT every falling edge, and directed
// sequences carry hand-computed literal expectations. Define FETCH_IRQ_EN
// to exercise the interrupt path.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

`ifdef FETCH_IRQ_EN
    localparam bit IrqEnabled = 1'b1;
`else
    localparam bit IrqEnabled = 1'b0;
`endif
    localparam logic [11:0] ResetVector = 12'h000;
    localparam logic [11:0] IrqVector   = 12'h004;

    logic        clock;
    logic        reset_n;
    logic        stall_f;
    logic        branch_taken_e;
    logic [11:0] branch_target_e;
    logic        reti_e;
    logic        irq;
    logic [11:0] instr_adr;
    logic [15:0] instr_data;
    logic [15:0] instr_d;
    logic [11:0] pc_d;
    logic        valid_d;
    logic        irq_ack;
    logic [11:0] epc;

    int checks = 0;
    int errors = 0;

    logic [11:0] modelPc;
    logic        modelBoot;
    logic        modelIsr;
    logic [11:0] modelEpc;
    logic        modelTake;
    logic [11:0] modelNext;

    instruction_fetch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall_f         (stall_f),
        .branch_taken_e  (branch_taken_e),
        .branch_target_e (branch_target_e),
        .reti_e          (reti_e),
        .irq             (irq),
        .instr_adr       (instr_adr),
        .instr_data      (instr_data),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .valid_d         (valid_d),
        .irq_ack         (irq_ack),
        .epc             (epc)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] romWord(input logic [11:0] addr);
        return 16'h1000 + {4'h0, addr};
    endfunction

    // Synchronous ROM: contents are 16'h1000 + address.
    always @(posedge clock) begin
        instr_data <= romWord(instr_adr);
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time,
                     actual, expected);
        end
    endtask

    // One cycle of stimulus: inputs change 2 time units after the edge.
    task automatic applyStimulus(input logic st, input logic br,
                                 input logic [11:0] tgt, input logic rt,
                                 input logic iq);
        @(posedge clock);
        #2;
        stall_f         = st;
        branch_taken_e  = br;
        branch_target_e = tgt;
        reti_e          = rt;
        irq             = iq;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    // Reference model: on each falling edge, checks outputs against the
    // fetch rules, then commits what the next rising edge must produce.
    always @(negedge clock) begin
        if (!reset_n) begin
            modelPc   = ResetVector;
            modelBoot = 1'b1;
            modelIsr  = 1'b0;
            modelEpc  = 12'h000;
        end
        modelTake = IrqEnabled && !modelBoot && !modelIsr && irq &&
                    !branch_taken_e && !reti_e && !stall_f;
        if (modelBoot)                   modelNext = modelPc;
        else if (branch_taken_e)         modelNext = branch_target_e;
        else if (IrqEnabled && reti_e)   modelNext = modelEpc;
        else if (modelTake)              modelNext = IrqVector;
        else if (stall_f)                modelNext = modelPc;
        else                             modelNext = modelPc + 12'd1;

        checkOutput("model pc_d", {4'h0, pc_d}, {4'h0, modelPc});
        checkOutput("model valid_d", {15'h0, valid_d}, {15'h0, !modelBoot});
        checkOutput("model instr_adr", {4'h0, instr_adr}, {4'h0, modelNext});
        checkOutput("model irq_ack", {15'h0, irq_ack}, {15'h0, modelTake});
        checkOutput("model epc", {4'h0, epc}, {4'h0, modelEpc});
        if (!modelBoot) begin
            checkOutput("model instr_d", instr_d, romWord(modelPc));
        end

        if (reset_n) begin
            if (modelTake) begin
                modelEpc = modelPc;
                modelIsr = 1'b1;
            end else if (modelIsr && reti_e && !branch_taken_e) begin
                modelIsr = 1'b0;
            end
            modelBoot = 1'b0;
            modelPc   = modelNext;
        end
    end

    // Directed sequences with hand-computed values.
    initial begin
        reset_n         = 1'b0;
        stall_f         = 1'b0;
        branch_taken_e  = 1'b0;
        branch_target_e = 12'h000;
        reti_e          = 1'b0;
        irq             = 1'b0;
        modelPc         = ResetVector;
        modelBoot       = 1'b1;
        modelIsr        = 1'b0;
        modelEpc        = 12'h000;

        // Reset release and ROM priming.
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        checkOutput("boot valid_d", {15'h0, valid_d}, 16'h0000);
        checkOutput("boot instr_adr", {4'h0, instr_adr}, 16'h0000);
        checkOutput("boot pc_d", {4'h0, pc_d}, 16'h0000);
        idle();
        checkOutput("first valid_d", {15'h0, valid_d}, 16'h0001);
        checkOutput("first instr_d", instr_d, 16'h1000);
        checkOutput("first pc_d", {4'h0, pc_d}, 16'h0000);
        checkOutput("first instr_adr", {4'h0, instr_adr}, 16'h0001);
        idle();
        checkOutput("second instr_d", instr_d, 16'h1001);
        checkOutput("second pc_d", {4'h0, pc_d}, 16'h0001);
        checkOutput("second instr_adr", {4'h0, instr_adr}, 16'h0002);

        // Two-cycle stall at pc_d=005.
        idle();
        idle();
        idle();
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        checkOutput("stall0 pc_d", {4'h0, pc_d}, 16'h0005);
        checkOutput("stall0 instr_adr", {4'h0, instr_adr}, 16'h0005);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        checkOutput("stall1 pc_d", {4'h0, pc_d}, 16'h0005);
        checkOutput("stall1 instr_d", instr_d, 16'h1005);
        idle();
        checkOutput("stall2 instr_d", instr_d, 16'h1005);
        checkOutput("stall2 instr_adr", {4'h0, instr_adr}, 16'h0006);
        idle();
        checkOutput("resume pc_d", {4'h0, pc_d}, 16'h0006);
        checkOutput("resume instr_d", instr_d, 16'h1006);

        // Branch overriding a simultaneous stall.
        applyStimulus(1'b1, 1'b1, 12'h040, 1'b0, 1'b0);
        checkOutput("branch instr_adr", {4'h0, instr_adr}, 16'h0040);
        idle();
        checkOutput("branch pc_d", {4'h0, pc_d}, 16'h0040);
        checkOutput("branch instr_d", instr_d, 16'h1040);
        checkOutput("branch valid_d", {15'h0, valid_d}, 16'h0001);

`ifndef FETCH_IRQ_EN
        // irq and reti_e must not disturb the sequential fetch.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("noirq pc_d", {4'h0, pc_d}, 16'h0041);
        checkOutput("noirq irq_ack", {15'h0, irq_ack}, 16'h0000);
        checkOutput("noirq instr_adr", {4'h0, instr_adr}, 16'h0042);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        checkOutput("noreti instr_adr", {4'h0, instr_adr}, 16'h0043);
        checkOutput("noreti epc", {4'h0, epc}, 16'h0000);
        idle();
        checkOutput("noirq seq pc_d", {4'h0, pc_d}, 16'h0043);
`else
        // Interrupt entry at pc_d=010, irq held through the ISR.
        applyStimulus(1'b0, 1'b1, 12'h010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("irq pc_d", {4'h0, pc_d}, 16'h0010);
        checkOutput("irq ack", {15'h0, irq_ack}, 16'h0001);
        checkOutput("irq instr_adr", {4'h0, instr_adr}, 16'h0004);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("isr instr_d", instr_d, 16'h1004);
        checkOutput("isr epc", {4'h0, epc}, 16'h0010);
        checkOutput("isr no reack", {15'h0, irq_ack}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("isr no reack2", {15'h0, irq_ack}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkOutput("reti instr_adr", {4'h0, instr_adr}, 16'h0010);
        idle();
        checkOutput("reti pc_d", {4'h0, pc_d}, 16'h0010);
        checkOutput("reti instr_d", instr_d, 16'h1010);

        // irq blocked by a branch is taken on the next cycle.
        applyStimulus(1'b0, 1'b1, 12'h020, 1'b0, 1'b1);
        checkOutput("blocked irq_ack", {15'h0, irq_ack}, 16'h0000);
        checkOutput("blocked instr_adr", {4'h0, instr_adr}, 16'h0020);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("retry irq_ack", {15'h0, irq_ack}, 16'h0001);
        checkOutput("retry pc_d", {4'h0, pc_d}, 16'h0020);

        // Branch and reti together: branch wins, still in ISR.
        applyStimulus(1'b0, 1'b1, 12'h030, 1'b1, 1'b0);
        checkOutput("retry epc", {4'h0, epc}, 16'h0020);
        checkOutput("br+reti instr_adr", {4'h0, instr_adr}, 16'h0030);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("still isr irq_ack", {15'h0, irq_ack}, 16'h0000);
        checkOutput("still isr instr_adr", {4'h0, instr_adr}, 16'h0031);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkOutput("reti2 instr_adr", {4'h0, instr_adr}, 16'h0020);
        idle();

        // Asynchronous reset in the middle of an ISR.
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("irq3 ack", {15'h0, irq_ack}, 16'h0001);
        idle();
        checkOutput("irq3 epc", {4'h0, epc}, 16'h0021);
        reset_n = 1'b0;
        #1;
        checkOutput("async rst pc_d", {4'h0, pc_d}, 16'h0000);
        checkOutput("async rst epc", {4'h0, epc}, 16'h0000);
        checkOutput("async rst valid_d", {15'h0, valid_d}, 16'h0000);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        irq     = 1'b1;
        #1;
        checkOutput("reboot irq_ack", {15'h0, irq_ack}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        checkOutput("ie after rst ack", {15'h0, irq_ack}, 16'h0001);
        checkOutput("ie after rst adr", {4'h0, instr_adr}, 16'h0004);
        idle();
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        checkOutput("reti3 instr_adr", {4'h0, instr_adr}, 16'h0000);
        idle();
`endif

        // Address wrap at the top of the PC range.
        applyStimulus(1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
        idle();
        checkOutput("wrap pc FFE", {4'h0, pc_d}, 16'h0FFE);
        idle();
        checkOutput("wrap pc FFF", {4'h0, pc_d}, 16'h0FFF);
        checkOutput("wrap instr FFF", instr_d, 16'h1FFF);
        checkOutput("wrap instr_adr", {4'h0, instr_adr}, 16'h0000);
        idle();
        checkOutput("wrap pc 000", {4'h0, pc_d}, 16'h0000);
        checkOutput("wrap instr 000", instr_d, 16'h1000);
        idle();
        idle();

        @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
